// File: rtl/dtree_engine.sv
// dtree_engine: oblique decision-tree classifier; one shared MAC walks a heap-indexed tree.
// Build option: define DTREE_SATURATE_EN to clamp the accumulator instead of wrapping.
module dtree_engine #(
    parameter int FEATURES    = 3,
    parameter int DEPTH       = 3,
    parameter int IN_WIDTH    = 10,
    parameter int COEFF_WIDTH = 4,
    parameter int ACC_WIDTH   = IN_WIDTH + 2,
    localparam int NODES      = (1 << DEPTH) - 1,
    localparam int MEM_N      = NODES * (FEATURES + 1),
    localparam int ADDR_W     = $clog2(MEM_N),
    localparam int LEAF_W     = $clog2(1 << DEPTH),
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                cfg_we,
    input  logic [ADDR_W-1:0]   cfg_addr,
    input  logic [IN_WIDTH-1:0] cfg_data,
    output logic [DEPTH-1:0]    path,
    output logic [LEAF_W-1:0]   leaf,
    output logic [LVL_W-1:0]    level,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overflow
);
    localparam int FW = (FEATURES > 1) ? $clog2(FEATURES) : 1;
    localparam int SW = $clog2(FEATURES + 1);
    localparam int PW = IN_WIDTH + COEFF_WIDTH;
    localparam int XW = ACC_WIDTH + 1;
    localparam int NW = DEPTH + 1;

    typedef enum logic [1:0] {S_COLLECT, S_EVAL, S_DONE} state_t;
    state_t state_q, state_d;

    logic [FW-1:0]               feat_q, feat_d;
    logic [SW-1:0]               step_q, step_d;
    logic [LVL_W-1:0]            level_q, level_d;
    logic [DEPTH-1:0]            node_q, node_d;
    logic [DEPTH-1:0]            path_q, path_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        ovf_q, ovf_d;

    logic signed [IN_WIDTH-1:0]  x_q [FEATURES];
    logic signed [IN_WIDTH-1:0]  cfg_mem [MEM_N];

    logic                          accept, last_sample, last_step, last_level;
    logic [ADDR_W-1:0]             rd_addr;
    logic signed [IN_WIDTH-1:0]    rd_word, x_sel;
    logic signed [COEFF_WIDTH-1:0] coeff;
    logic signed [PW-1:0]          prod, term;
    logic signed [XW-1:0]          sum;
    logic signed [ACC_WIDTH-1:0]   acc_mac, acc_new;
    logic                          step_ovf, dir;

    // Step 0 of a level reads the node bias, step k reads coeff k-1 from the same row.
    always_comb begin
        rd_addr  = ADDR_W'(32'(node_q) * 32'(FEATURES + 1) + 32'(step_q));
        rd_word  = cfg_mem[rd_addr];
        coeff    = rd_word[COEFF_WIDTH-1:0];
        x_sel    = x_q[FW'(step_q - SW'(1))];
        prod     = x_sel * coeff;
        term     = prod >>> (COEFF_WIDTH - 1);
        sum      = XW'(acc_q) + XW'(term);
        step_ovf = (sum[XW-1] != sum[XW-2]);
`ifdef DTREE_SATURATE_EN
        if (step_ovf)
            acc_mac = sum[XW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        else
            acc_mac = sum[ACC_WIDTH-1:0];
`else
        acc_mac = sum[ACC_WIDTH-1:0];
`endif
        acc_new  = (step_q == '0) ? ACC_WIDTH'(rd_word) : acc_mac;
        dir      = acc_new[ACC_WIDTH-1];
    end

    always_comb begin
        accept      = (state_q == S_COLLECT) && sample_valid;
        last_sample = accept && (feat_q == FW'(FEATURES - 1));
        last_step   = (state_q == S_EVAL) && (step_q == SW'(FEATURES));
        last_level  = (level_q == LVL_W'(DEPTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_COLLECT;
            feat_q  <= '0;
            step_q  <= '0;
            level_q <= '0;
            node_q  <= '0;
            path_q  <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            feat_q  <= feat_d;
            step_q  <= step_d;
            level_q <= level_d;
            node_q  <= node_d;
            path_q  <= path_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Feature slots and coefficient memory are plain storage and survive reset.
    always_ff @(posedge clk) begin
        if (accept)
            x_q[feat_q] <= sample;
        if (cfg_we && (state_q == S_COLLECT) && (32'(cfg_addr) < 32'(MEM_N)))
            cfg_mem[cfg_addr] <= cfg_data;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (last_sample) state_d = S_EVAL;
            S_EVAL:    if (last_step && last_level) state_d = S_DONE;
            S_DONE:    if (out_ready) state_d = S_COLLECT;
            default:   state_d = S_COLLECT;
        endcase
    end

    always_comb begin
        feat_d  = feat_q;
        step_d  = step_q;
        level_d = level_q;
        node_d  = node_q;
        path_d  = path_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        if (accept)
            feat_d = last_sample ? '0 : feat_q + FW'(1);
        if (last_sample) begin
            step_d  = '0;
            level_d = '0;
            node_d  = '0;
            path_d  = '0;
            ovf_d   = 1'b0;
        end
        if (state_q == S_EVAL) begin
            acc_d = acc_new;
            if (step_q != '0)
                ovf_d = ovf_q | step_ovf;
            if (last_step) begin
                step_d  = '0;
                path_d  = DEPTH'({path_q, dir});
                node_d  = DEPTH'({node_q, 1'b0} + NW'(1) + NW'(dir));
                level_d = last_level ? '0 : level_q + LVL_W'(1);
            end else begin
                step_d = step_q + SW'(1);
            end
        end
    end

    always_comb begin
        sample_ready = (state_q == S_COLLECT);
        out_valid    = (state_q == S_DONE);
        level        = (state_q == S_EVAL) ? level_q : '0;
        path         = path_q;
        leaf         = LEAF_W'(path_q);
        overflow     = ovf_q;
    end
endmodule
